// File: rtl/nanorv32_ahb_arb2.sv
// nanorv32_ahb_arb2: two-master AHB-lite arbiter with per-master one-entry pending buffers.
module nanorv32_ahb_arb2 #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            m0_htrans,
   input  logic [ADDR_WIDTH-1:0] m0_haddr,
   input  logic                  m0_hwrite,
   input  logic [2:0]            m0_hsize,
   input  logic [DATA_WIDTH-1:0] m0_hwdata,
   output logic [DATA_WIDTH-1:0] m0_hrdata,
   output logic                  m0_hready,
   output logic                  m0_hresp,
   input  logic [1:0]            m1_htrans,
   input  logic [ADDR_WIDTH-1:0] m1_haddr,
   input  logic                  m1_hwrite,
   input  logic [2:0]            m1_hsize,
   input  logic [DATA_WIDTH-1:0] m1_hwdata,
   output logic [DATA_WIDTH-1:0] m1_hrdata,
   output logic                  m1_hready,
   output logic                  m1_hresp,
   output logic [1:0]            s_htrans,
   output logic [ADDR_WIDTH-1:0] s_haddr,
   output logic                  s_hwrite,
   output logic [2:0]            s_hsize,
   output logic [DATA_WIDTH-1:0] s_hwdata,
   input  logic [DATA_WIDTH-1:0] s_hrdata,
   input  logic                  s_hready,
   input  logic                  s_hresp
);
   typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} own_t;
   own_t                  own_q, own_d;
   logic [1:0]            pend_v_q, pend_v_d, write_q, write_d, cap, rdy;
   logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
   logic [2:0]            size0_q, size0_d, size1_q, size1_d;
   logic                  last_q, last_d, hold_q, hold_d, win_q, win_d;
   logic                  any, win, accept, unused_ok;
   assign unused_ok = ^{m0_htrans[0], m1_htrans[0]};
   always_comb begin
      any = |pend_v_q;
      win = hold_q ? win_q : (&pend_v_q ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_q) : pend_v_q[1]);
      accept = any & s_hready;
      rdy[0] = rst | (~pend_v_q[0] & ((own_q != OWN_M0) | s_hready));
      rdy[1] = rst | (~pend_v_q[1] & ((own_q != OWN_M1) | s_hready));
      cap = {m1_htrans[1] & rdy[1], m0_htrans[1] & rdy[0]};
      pend_v_d = (pend_v_q & ~({win, ~win} & {2{accept}})) | cap;
      own_d = s_hready ? (any ? (win ? OWN_M1 : OWN_M0) : OWN_NONE) : own_q;
      last_d = accept ? win : last_q;
      hold_d = any & ~s_hready;
      win_d = win;
      addr0_d = cap[0] ? m0_haddr : addr0_q;
      addr1_d = cap[1] ? m1_haddr : addr1_q;
      size0_d = cap[0] ? m0_hsize : size0_q;
      size1_d = cap[1] ? m1_hsize : size1_q;
      write_d = {cap[1] ? m1_hwrite : write_q[1], cap[0] ? m0_hwrite : write_q[0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_v_q <= '0;
         own_q    <= OWN_NONE;
         last_q   <= 1'b1;
         hold_q   <= 1'b0;
         win_q    <= 1'b0;
      end else begin
         pend_v_q <= pend_v_d;
         own_q    <= own_d;
         last_q   <= last_d;
         hold_q   <= hold_d;
         win_q    <= win_d;
      end
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      size0_q <= size0_d;
      size1_q <= size1_d;
      write_q <= write_d;
   end
   assign m0_hready = rdy[0];
   assign m1_hready = rdy[1];
   assign m0_hresp  = ~rst & (own_q == OWN_M0) & s_hresp;
   assign m1_hresp  = ~rst & (own_q == OWN_M1) & s_hresp;
   assign m0_hrdata = s_hrdata;
   assign m1_hrdata = s_hrdata;
   assign s_htrans  = (any & ~rst) ? 2'b10 : 2'b00;
   assign s_haddr   = win ? addr1_q : addr0_q;
   assign s_hwrite  = win ? write_q[1] : write_q[0];
   assign s_hsize   = win ? size1_q : size0_q;
   assign s_hwdata  = (own_q == OWN_M0) ? m0_hwdata : (own_q == OWN_M1) ? m1_hwdata : '0;
endmodule

// File: tb/tb_nanorv32_ahb_arb2.sv
// tb_nanorv32_ahb_arb2: vector table, corner sequences and random run against a rule-level model.
module tb_nanorv32_ahb_arb2;
   logic        clk = 1'b0, rst = 1'b1;
   logic [1:0]  htr [2];
   logic [31:0] ha [2], hwd [2];
   logic [1:0]  hw;
   logic [2:0]  hs [2];
   logic [31:0] srd;
   logic        shr, sre;
   logic [1:0]  sht [2];
   logic [31:0] sha [2], shwd [2], hrd [4];
   logic [1:0]  shw;
   logic [2:0]  shs [2];
   logic [3:0]  rdy, rsp;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   nanorv32_ahb_arb2 #(.FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .m0_htrans(htr[0]), .m0_haddr(ha[0]), .m0_hwrite(hw[0]), .m0_hsize(hs[0]), .m0_hwdata(hwd[0]),
      .m0_hrdata(hrd[0]), .m0_hready(rdy[0]), .m0_hresp(rsp[0]),
      .m1_htrans(htr[1]), .m1_haddr(ha[1]), .m1_hwrite(hw[1]), .m1_hsize(hs[1]), .m1_hwdata(hwd[1]),
      .m1_hrdata(hrd[1]), .m1_hready(rdy[1]), .m1_hresp(rsp[1]),
      .s_htrans(sht[0]), .s_haddr(sha[0]), .s_hwrite(shw[0]), .s_hsize(shs[0]), .s_hwdata(shwd[0]),
      .s_hrdata(srd), .s_hready(shr), .s_hresp(sre));
   nanorv32_ahb_arb2 #(.FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_htrans(htr[0]), .m0_haddr(ha[0]), .m0_hwrite(hw[0]), .m0_hsize(hs[0]), .m0_hwdata(hwd[0]),
      .m0_hrdata(hrd[2]), .m0_hready(rdy[2]), .m0_hresp(rsp[2]),
      .m1_htrans(htr[1]), .m1_haddr(ha[1]), .m1_hwrite(hw[1]), .m1_hsize(hs[1]), .m1_hwdata(hwd[1]),
      .m1_hrdata(hrd[3]), .m1_hready(rdy[3]), .m1_hresp(rsp[3]),
      .s_htrans(sht[1]), .s_haddr(sha[1]), .s_hwrite(shw[1]), .s_hsize(shs[1]), .s_hwdata(shwd[1]),
      .s_hrdata(srd), .s_hready(shr), .s_hresp(sre));
   // Reference model: index 0 round-robin, index 1 fixed priority; -1 means no owner/winner
   int pend [2][2];
   int own [2], last [2], hold [2], hwin [2];
   logic [31:0] ca [2][2];
   logic        cw [2][2];
   logic [2:0]  cs [2][2];
   function automatic int pick(int k);
      if (hold[k] != 0) return hwin[k];
      if (pend[k][0] != 0 && pend[k][1] != 0) return (k == 1) ? 0 : 1 - last[k];
      if (pend[k][0] != 0) return 0;
      if (pend[k][1] != 0) return 1;
      return -1;
   endfunction
   function automatic logic exp_rdy(int k, int m);
      return rst || (pend[k][m] == 0 && (own[k] != m || shr));
   endfunction
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int w;
         logic c [2];
         w = pick(k);
         for (int m = 0; m < 2; m++) c[m] = htr[m][1] && exp_rdy(k, m);
         if (rst) begin
            pend[k][0] = 0; pend[k][1] = 0; own[k] = -1; last[k] = 1; hold[k] = 0; hwin[k] = -1;
         end else begin
            if (shr) begin
               if (w >= 0) begin pend[k][w] = 0; own[k] = w; last[k] = w; end
               else own[k] = -1;
            end
            hold[k] = (w >= 0 && !shr) ? 1 : 0;
            hwin[k] = w;
            for (int m = 0; m < 2; m++)
               if (c[m]) begin pend[k][m] = 1; ca[k][m] = ha[m]; cw[k][m] = hw[m]; cs[k][m] = hs[m]; end
         end
      end
   endtask
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic do_reset();
      rst = 1'b1; htr[0] = 2'b00; htr[1] = 2'b00; shr = 1'b1; sre = 1'b0;
      tick();
      rst = 1'b0;
   endtask
   typedef struct {
      logic rst, r0, r1, shr, sre;
      logic ns, sel, rdy0, rdy1, rsp0, rsp1;
   } vec_t;
   vec_t tbl [18];
   initial begin
      tbl[0]  = '{0,1,0,1,0, 0,0,1,1,0,0};
      tbl[1]  = '{0,0,0,1,0, 1,0,0,1,0,0};
      tbl[2]  = '{0,0,0,1,0, 0,0,1,1,0,0};
      tbl[3]  = '{1,0,0,1,0, 0,0,1,1,0,0};
      tbl[4]  = '{0,1,1,1,0, 0,0,1,1,0,0};
      tbl[5]  = '{0,0,0,1,0, 1,0,0,0,0,0};
      tbl[6]  = '{0,0,0,1,0, 1,1,1,0,0,0};
      tbl[7]  = '{0,1,0,1,0, 0,0,1,1,0,0};
      tbl[8]  = '{0,0,0,1,0, 1,0,0,1,0,0};
      tbl[9]  = '{0,1,1,1,0, 0,0,1,1,0,0};
      tbl[10] = '{0,0,0,1,0, 1,1,0,0,0,0};
      tbl[11] = '{0,0,0,1,0, 1,0,0,1,0,0};
      tbl[12] = '{0,0,0,1,0, 0,0,1,1,0,0};
      tbl[13] = '{0,1,0,1,0, 0,0,1,1,0,0};
      tbl[14] = '{0,0,0,1,0, 1,0,0,1,0,0};
      tbl[15] = '{0,0,0,0,1, 0,0,0,1,1,0};
      tbl[16] = '{0,0,0,1,1, 0,0,1,1,1,0};
      tbl[17] = '{0,0,0,1,0, 0,0,1,1,0,0};
      ha[0] = 32'h0000_0100; ha[1] = 32'h0000_0200; hw = 2'b00; hs[0] = 3'd2; hs[1] = 3'd2;
      hwd[0] = '0; hwd[1] = '0; srd = '0;
      do_reset();
      do_reset();
      for (int i = 0; i < 18; i++) begin
         rst = tbl[i].rst; shr = tbl[i].shr; sre = tbl[i].sre;
         htr[0] = tbl[i].r0 ? 2'b10 : 2'b00;
         htr[1] = tbl[i].r1 ? 2'b10 : 2'b00;
         srd = 32'hD000_0000 + i;
         #2;
         chk($sformatf("tbl%0d_htrans", i), sht[0], tbl[i].ns ? 2'b10 : 2'b00);
         if (tbl[i].ns) chk($sformatf("tbl%0d_haddr", i), sha[0], tbl[i].sel ? 32'h200 : 32'h100);
         chk($sformatf("tbl%0d_rdy0", i), rdy[0], tbl[i].rdy0);
         chk($sformatf("tbl%0d_rdy1", i), rdy[1], tbl[i].rdy1);
         chk($sformatf("tbl%0d_rsp0", i), rsp[0], tbl[i].rsp0);
         chk($sformatf("tbl%0d_rsp1", i), rsp[1], tbl[i].rsp1);
         chk($sformatf("tbl%0d_rdata", i), hrd[0], 32'hD000_0000 + i);
         tick();
      end
      // m1 write stalled by slave; a new m0 request must not disturb the frozen address phase
      do_reset();
      ha[1] = 32'hCAFF_E000; hw = 2'b10; ha[0] = 32'h0000_0300;
      htr[1] = 2'b10; tick();
      htr[1] = 2'b00; htr[0] = 2'b10; shr = 1'b0; #2;
      chk("stall_htrans", sht[0], 2'b10);
      chk("stall_hwrite", shw[0], 1'b1);
      chk("stall_rdy1", rdy[1], 1'b0);
      chk("stall_rdy0", rdy[0], 1'b1);
      tick();
      htr[0] = 2'b00;
      for (int i = 0; i < 3; i++) begin
         shr = (i == 2); #2;
         chk("stall_haddr", sha[0], 32'hCAFF_E000);
         tick();
      end
      hwd[1] = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         shr = (i == 3); #2;
         chk("stall_dp_haddr", sha[0], 32'h0000_0300);
         chk("stall_hwdata", shwd[0], 32'h1234_5678);
         chk("stall_dp_rdy1", rdy[1], i == 3);
         tick();
      end
      // reset while m1 pending and m0 in its data phase
      do_reset();
      ha[0] = 32'h100; ha[1] = 32'h200; hw = 2'b00;
      htr[0] = 2'b10; tick();
      htr[0] = 2'b00; htr[1] = 2'b10; #2;
      chk("rst_pre_rdy1", rdy[1], 1'b1);
      chk("rst_pre_haddr", sha[0], 32'h100);
      tick();
      htr[1] = 2'b00; shr = 1'b0; rst = 1'b1; #2;
      chk("rst_in_htrans", sht[0], 2'b00);
      chk("rst_in_rdy0", rdy[0], 1'b1);
      chk("rst_in_rdy1", rdy[1], 1'b1);
      tick();
      rst = 1'b0; shr = 1'b1; #2;
      chk("rst_post_htrans", sht[0], 2'b00);
      chk("rst_post_rdy0", rdy[0], 1'b1);
      chk("rst_post_rdy1", rdy[1], 1'b1);
      tick();
      // fixed priority: m0 wins collision even when round-robin would pick m1
      do_reset();
      htr[0] = 2'b10; tick();
      #2; chk("fp_first", sha[1], 32'h100);
      tick();
      htr[1] = 2'b10; #2;
      chk("fp_cap_rdy0", rdy[2], 1'b1);
      chk("fp_cap_rdy1", rdy[3], 1'b1);
      tick();
      htr[1] = 2'b00; #2;
      chk("fp_coll_haddr", sha[1], 32'h100);
      chk("fp_coll_rdy1", rdy[3], 1'b0);
      chk("rr_coll_haddr", sha[0], 32'h200);
      tick();
      #2;
      chk("fp_gap_haddr", sha[1], 32'h200);
      chk("fp_gap_rdy0", rdy[2], 1'b1);
      tick();
      htr[0] = 2'b00;
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         for (int m = 0; m < 2; m++) begin
            htr[m] = ($urandom_range(1) != 0) ? (($urandom_range(1) != 0) ? 2'b11 : 2'b10) : 2'b00;
            ha[m] = $urandom; hwd[m] = $urandom; hs[m] = 3'($urandom_range(7)); hw[m] = 1'($urandom_range(1));
         end
         srd = $urandom; shr = ($urandom_range(3) != 0); sre = ($urandom_range(7) == 0);
         #2;
         for (int k = 0; k < 2; k++) begin
            int w;
            string p;
            p = (k == 1) ? "fp_" : "rr_";
            w = pick(k);
            chk({p, "r_htrans"}, sht[k], (w < 0) ? 2'b00 : 2'b10);
            if (w >= 0) begin
               chk({p, "r_haddr"}, sha[k], ca[k][w]);
               chk({p, "r_hwrite"}, shw[k], cw[k][w]);
               chk({p, "r_hsize"}, shs[k], cs[k][w]);
            end
            chk({p, "r_hwdata"}, shwd[k], (own[k] < 0) ? 32'h0 : hwd[own[k]]);
            for (int m = 0; m < 2; m++) begin
               chk({p, "r_rdy"}, rdy[2*k+m], exp_rdy(k, m));
               chk({p, "r_rsp"}, rsp[2*k+m], own[k] == m && sre);
               chk({p, "r_rdata"}, hrd[2*k+m], srd);
            end
         end
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
